// File: rtl/reorder_ctrl_mb.sv
// Multi-bank reorder controller: NB frame banks cycle IDLE -> CAP -> DEC -> OUT as a FIFO ring.
// Define REORDER_CTRL_STATS_EN to add saturating drop/exceed/frame counters.
module reorder_ctrl_mb #(
  parameter int unsigned W  = 10,
  parameter int unsigned N  = 544,
  parameter int unsigned NB = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     synd_start_i,
  input  logic                     synd_last_i,
  input  logic                     ecc_valid_i,
  input  logic                     exceed_i,
  input  logic                     recorrect_done_i,
  input  logic                     forney_vld_i,
  input  logic [9:0]               forney_pos_i,
  input  logic [W-1:0]             forney_y_i,
  output logic                     forney_s3_rdy_o,
  output logic                     cap_rdy_o,
  output logic [$clog2(NB)-1:0]    cap_sel_o,
  output logic                     apply_en_o,
  output logic [$clog2(NB)-1:0]    apply_sel_o,
  output logic [9:0]               apply_pos_o,
  output logic [W-1:0]             apply_y_o,
  output logic                     out_vld_o,
  output logic [$clog2(NB)-1:0]    out_sel_o,
  output logic                     out_use_rec_o,
  input  logic                     out_done_i,
  output logic                     ovf_o
`ifdef REORDER_CTRL_STATS_EN
  ,
  output logic [15:0]              drop_cnt_o,
  output logic [15:0]              exceed_cnt_o,
  output logic [15:0]              frame_cnt_o
`endif
);

  localparam int unsigned BW = $clog2(NB);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAP  = 2'd1,
    ST_DEC  = 2'd2,
    ST_OUT  = 2'd3
  } bank_st_e;

  bank_st_e        state_q [NB];
  logic [BW-1:0]   cap_ptr_q, app_ptr_q, out_ptr_q;
  logic [NB-1:0]   use_fix_q, use_rec_q;
  logic            dec_seen_q, ovf_q;
  logic            apply_en_q;
  logic [BW-1:0]   apply_sel_q;
  logic [9:0]      apply_pos_q;
  logic [W-1:0]    apply_y_q;

  logic            last_fire, start_ok, app_dec, accept, pos_ok, fix_hit, complete, drain;
  logic [BW-1:0]   start_sel;

  // A same-cycle last advances the capture bank before the start is judged.
  always_comb begin
    last_fire = synd_last_i && (state_q[cap_ptr_q] == ST_CAP);
    start_sel = last_fire ? (cap_ptr_q + BW'(1)) : cap_ptr_q;
    start_ok  = synd_start_i && (state_q[start_sel] == ST_IDLE);
    app_dec   = (state_q[app_ptr_q] == ST_DEC);
    accept    = forney_vld_i && dec_seen_q && app_dec;
    pos_ok    = 32'(forney_pos_i) < N;
    fix_hit   = accept && use_fix_q[app_ptr_q] && pos_ok;
    complete  = recorrect_done_i && app_dec;
    drain     = out_done_i && (state_q[out_ptr_q] == ST_OUT);
  end

  assign forney_s3_rdy_o = dec_seen_q && app_dec;
  assign cap_rdy_o       = (state_q[cap_ptr_q] == ST_IDLE);
  assign cap_sel_o       = cap_ptr_q;
  assign out_vld_o       = (state_q[out_ptr_q] == ST_OUT);
  assign out_sel_o       = out_ptr_q;
  assign out_use_rec_o   = use_rec_q[out_ptr_q];
  assign apply_en_o      = apply_en_q;
  assign apply_sel_o     = apply_sel_q;
  assign apply_pos_o     = apply_pos_q;
  assign apply_y_o       = apply_y_q;
  assign ovf_o           = ovf_q;

  // Bank ring; each phase touches a distinct bank, so the writes never collide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NB); i++) state_q[i] <= ST_IDLE;
      cap_ptr_q   <= '0;
      app_ptr_q   <= '0;
      out_ptr_q   <= '0;
      use_fix_q   <= '0;
      use_rec_q   <= '0;
      dec_seen_q  <= 1'b0;
      ovf_q       <= 1'b0;
      apply_en_q  <= 1'b0;
      apply_sel_q <= '0;
      apply_pos_q <= '0;
      apply_y_q   <= '0;
    end else begin
      if (last_fire) begin
        state_q[cap_ptr_q] <= ST_DEC;
        cap_ptr_q          <= cap_ptr_q + BW'(1);
      end
      if (start_ok) begin
        state_q[start_sel] <= ST_CAP;
      end else if (synd_start_i) begin
        ovf_q <= 1'b1;
      end
      if (ecc_valid_i && app_dec) begin
        use_fix_q[app_ptr_q] <= ~exceed_i;
        dec_seen_q           <= 1'b1;
      end
      apply_en_q <= fix_hit;
      if (accept) begin
        apply_sel_q <= app_ptr_q;
        apply_pos_q <= forney_pos_i;
        apply_y_q   <= forney_y_i;
      end
      // Completion wins over a same-cycle decision; the decision state is sampled pre-cycle.
      if (complete) begin
        state_q[app_ptr_q]   <= ST_OUT;
        use_rec_q[app_ptr_q] <= dec_seen_q & use_fix_q[app_ptr_q];
        dec_seen_q           <= 1'b0;
        app_ptr_q            <= app_ptr_q + BW'(1);
      end
      if (drain) begin
        state_q[out_ptr_q] <= ST_IDLE;
        out_ptr_q          <= out_ptr_q + BW'(1);
      end
    end
  end

`ifdef REORDER_CTRL_STATS_EN
  logic [15:0] drop_cnt_q, exceed_cnt_q, frame_cnt_q;
  logic        rec_new;

  assign rec_new      = dec_seen_q & use_fix_q[app_ptr_q];
  assign drop_cnt_o   = drop_cnt_q;
  assign exceed_cnt_o = exceed_cnt_q;
  assign frame_cnt_o  = frame_cnt_q;

  // Saturating statistics.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_q   <= '0;
      exceed_cnt_q <= '0;
      frame_cnt_q  <= '0;
    end else begin
      if (accept && !fix_hit && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
      if (complete && !rec_new && (exceed_cnt_q != 16'hFFFF)) exceed_cnt_q <= exceed_cnt_q + 16'd1;
      if (complete && (frame_cnt_q != 16'hFFFF)) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
